// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multicycle RV32I main control FSM, ALU decoder and datapath.
// Holds opcodes, state codes, mux-select encodings and the Moore control bundle.
package multicycle_main_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10
    } state_e;

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBr  = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // State entered after DECODE; StFetch doubles as the "unsupported opcode" answer.
    function automatic state_e decode_target(logic [6:0] op);
        unique case (op)
            OpLw, OpSw: return StMemAdr;
            OpR:        return StExecR;
            OpI:        return StExecI;
            OpBr:       return StBranch;
            OpJal:      return StJal;
            default:    return StFetch;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control/status bundle between the main FSM and the datapath.
// The FSM owns the master side; the datapath consumes controls through the slave side.
interface multicycle_main_fsm_if #(
    parameter int unsigned STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               adr_src;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic               illegal_op;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  op, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, illegal_op, state_dbg
    );

    modport slave (
        output op, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, alu_op, illegal_op, state_dbg
    );
endinterface

// File: rtl/mfsm_output_decode.sv
// Combinational Moore decode: current state code -> datapath controls.
// Codes outside the defined state set decode to all-zero controls.
module mfsm_output_decode
    import multicycle_main_fsm_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    output ctrl_t              ctl
);

    logic   in_range;
    state_e cur;

    assign in_range = (state >> 4) == '0;
    assign cur      = state_e'(state[3:0]);

    always_comb begin
        ctl = '0;
        if (in_range) begin
            case (cur)
                StFetch: begin
                    ctl.alu_src_b  = SrcBFour;
                    ctl.result_src = ResAluResult;
                    ctl.ir_write   = 1'b1;
                    ctl.pc_update  = 1'b1;
                end
                StDecode: begin
                    ctl.alu_src_a = SrcAOldPc;
                    ctl.alu_src_b = SrcBImm;
                end
                StMemAdr: begin
                    ctl.alu_src_a = SrcARd1;
                    ctl.alu_src_b = SrcBImm;
                end
                StMemRead: begin
                    ctl.adr_src    = 1'b1;
                    ctl.result_src = ResAluOut;
                end
                StMemWb: begin
                    ctl.result_src = ResData;
                    ctl.reg_write  = 1'b1;
                end
                StMemWrite: begin
                    ctl.adr_src   = 1'b1;
                    ctl.mem_write = 1'b1;
                end
                StExecR: begin
                    ctl.alu_src_a = SrcARd1;
                    ctl.alu_src_b = SrcBRd2;
                    ctl.alu_op    = AluOpFunct;
                end
                StExecI: begin
                    ctl.alu_src_a = SrcARd1;
                    ctl.alu_src_b = SrcBImm;
                    ctl.alu_op    = AluOpFunct;
                end
                StAluWb: begin
                    ctl.result_src = ResAluOut;
                    ctl.reg_write  = 1'b1;
                end
                StBranch: begin
                    ctl.alu_src_a = SrcARd1;
                    ctl.alu_src_b = SrcBRd2;
                    ctl.alu_op    = AluOpSub;
                    ctl.branch    = 1'b1;
                end
                StJal: begin
                    ctl.alu_src_a = SrcAOldPc;
                    ctl.alu_src_b = SrcBFour;
                    ctl.pc_update = 1'b1;
                end
                default: ctl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: state register, next-state logic,
// the pc_write Mealy term and reset gating of every control output.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int unsigned STATE_W = 4  // must be >= 4
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_main_fsm_if.master bus
);

    logic [STATE_W-1:0] state_q;
    state_e             state_d;
    state_e             cur;
    logic               in_range;
    logic               illegal;
    logic               fetch_go;
    ctrl_t              ctl;
    logic               unused_funct3;

    assign in_range      = (state_q >> 4) == '0;
    assign cur           = state_e'(state_q[3:0]);
    assign unused_funct3 = ^bus.funct3[2:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= STATE_W'(state_d);
        end
    end

    always_comb begin
        state_d = StFetch;
        illegal = 1'b0;
        if (in_range) begin
            case (cur)
                StFetch:    state_d = bus.mem_ready ? StDecode : StFetch;
                StDecode: begin
                    state_d = decode_target(bus.op);
                    illegal = (state_d == StFetch);
                end
                StMemAdr:   state_d = bus.op[5] ? StMemWrite : StMemRead;
                StMemRead:  state_d = bus.mem_ready ? StMemWb : StMemRead;
                StMemWb:    state_d = StFetch;
                StMemWrite: state_d = bus.mem_ready ? StFetch : StMemWrite;
                StExecR:    state_d = StAluWb;
                StExecI:    state_d = StAluWb;
                StAluWb:    state_d = StFetch;
                StBranch:   state_d = StFetch;
                StJal:      state_d = StAluWb;
                default:    state_d = StFetch;
            endcase
        end
    end

    mfsm_output_decode #(
        .STATE_W(STATE_W)
    ) u_output_decode (
        .state(state_q),
        .ctl  (ctl)
    );

    // Only FETCH raises ir_write, so it marks where the PC/IR update waits on memory.
    assign fetch_go = ~ctl.ir_write | bus.mem_ready;

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.illegal_op = 1'b0;
        bus.state_dbg  = '0;
        if (!rst) begin
            bus.pc_write   = (ctl.pc_update & fetch_go)
                           | (ctl.branch & (bus.zero ^ bus.funct3[0]));
            bus.adr_src    = ctl.adr_src;
            bus.mem_write  = ctl.mem_write;
            bus.ir_write   = ctl.ir_write & bus.mem_ready;
            bus.reg_write  = ctl.reg_write;
            bus.result_src = ctl.result_src;
            bus.alu_src_a  = ctl.alu_src_a;
            bus.alu_src_b  = ctl.alu_src_b;
            bus.alu_op     = ctl.alu_op;
            bus.illegal_op = illegal;
            bus.state_dbg  = state_q;
        end
    end

endmodule
